instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 174 +++++++++++++++++
 tb/tb_instr_encoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs RV32 register/immediate fields into 32-bit words and
// queues each word, tagged with a sequential address, in a two-entry output FIFO.
package instr_encoder_pkg;
    typedef enum logic [6:0] {
        lw_op         = 7'b0000011,
        i_type_alu_op = 7'b0010011,
        sw_op         = 7'b0100011,
        r_type_op     = 7'b0110011,
        beq_op        = 7'b1100011,
        jal_op        = 7'b1101111
    } opcodetype_t;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  opcodetype_t in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [15:0] out_count
);

    logic [6:0]  w_op;
    logic [31:0] w_instr;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_range;
    logic        w_err;
    logic [1:0]  w_code;
    logic        w_imm_i_ok;
    logic        w_imm_b_ok;
    logic        w_imm_j_ok;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    logic [31:0] r_mem_instr [2];
    logic [31:0] r_mem_addr  [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic [31:0] r_addr;
    logic        r_err_valid;
    logic [1:0]  r_err_code;
    logic [15:0] r_out_count;

    assign w_op = in_op;

    // An immediate fits when every bit above the field's sign bit copies that sign bit.
    assign w_imm_i_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_imm_b_ok = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign w_imm_j_ok = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    always_comb begin
        w_instr      = '0;
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_range      = 1'b0;
        case (in_op)
            r_type_op: begin
                w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, w_op};
            end
            lw_op, i_type_alu_op: begin
                w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_op};
                w_range = !w_imm_i_ok;
            end
            sw_op: begin
                w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], w_op};
                w_range = !w_imm_i_ok;
            end
            beq_op: begin
                w_instr      = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], w_op};
                w_misaligned = in_imm[0];
                w_range      = !w_imm_b_ok;
            end
            jal_op: begin
                w_instr      = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, w_op};
                w_misaligned = in_imm[0];
                w_range      = !w_imm_j_ok;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_code = 2'd0;
        if (w_illegal) begin
            w_code = 2'd1;
        end else if (w_misaligned) begin
            w_code = 2'd3;
        end else if (w_range) begin
            w_code = 2'd2;
        end
    end

    assign w_err    = w_illegal || w_misaligned || w_range;
    assign w_full   = (r_count == 2'(DEPTH));
    assign w_empty  = (r_count == 2'd0);
    assign in_ready = !w_full && !restart && reset_n;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && !w_err;
    assign w_pop    = !w_empty && out_ready;

    // Storage carries no reset; occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= w_instr;
            r_mem_addr[r_wr_ptr]  <= r_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_addr      <= RESET_ADDR;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
            r_out_count <= 16'd0;
        end else if (restart) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_addr      <= RESET_ADDR;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                r_addr   <= r_addr + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr    <= ~r_rd_ptr;
                r_out_count <= r_out_count + 16'd1;
            end
            r_count     <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            r_err_valid <= w_accept && w_err;
            r_err_code  <= (w_accept && w_err) ? w_code : 2'd0;
        end
    end

    assign out_valid = !w_empty;
    assign out_instr = r_mem_instr[r_rd_ptr];
    assign out_addr  = r_mem_addr[r_rd_ptr];
    assign err_valid = r_err_valid;
    assign err_code  = r_err_code;
    assign out_count = r_out_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected {instr, addr} pairs are queued at
// acceptance and checked by a monitor on every output handshake.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        restart;
    logic        in_valid;
    logic        in_ready;
    opcodetype_t in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_valid;
    logic [1:0]  err_code;
    logic [15:0] out_count;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    instr_encoder #(.RESET_ADDR(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code), .out_count(out_count)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Handshake monitor: a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (reset_n && !restart && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected got=%h@%h expected=none", out_instr, out_addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({out_instr, out_addr} !== e) begin
                    bad++;
                    $display("FAIL out_word got=%h@%h expected=%h@%h",
                             out_instr, out_addr, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, output bit acc);
        in_op     = opcodetype_t'(op);
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic wait_drain(output bit ok);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b expected=0", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b expected=0", out_valid); end
        if (err_valid !== 1'b0) begin bad++; $display("FAIL rst_err_valid got=%b expected=0", err_valid); end
        if (err_code !== 2'd0) begin bad++; $display("FAIL rst_err_code got=%0d expected=0", err_code); end
        if (out_count !== 16'd0) begin bad++; $display("FAIL rst_out_count got=%0d expected=0", out_count); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b expected=1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid got=%b expected=0", out_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit acc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, acc);
        total++;
        if (acc !== 1'b1) begin bad++; $display("FAIL basic_accept got=%b expected=1", acc); end
        exp_q.push_back({32'h00500093, 32'h0});
        @(negedge clk);
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b expected=1", out_valid); end
        if (out_instr !== 32'h00500093) begin bad++; $display("FAIL basic_instr got=%h expected=00500093", out_instr); end
        if (out_addr !== 32'h0) begin bad++; $display("FAIL basic_addr got=%h expected=0", out_addr); end
        @(posedge clk);
        #1;
        wait_drain(ok);
        @(negedge clk);
        total += 2;
        if (!ok) begin bad++; $display("FAIL basic_drain got=%0d left expected=0", exp_q.size()); end
        if (out_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d expected=1", out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_formats();
        logic [6:0]  ops [7] = '{7'h63, 7'h23, 7'h33, 7'h03, 7'h6F, 7'h63, 7'h13};
        logic [4:0]  rds [7] = '{5'd0, 5'd0, 5'd3, 5'd5, 5'd1, 5'd0, 5'd0};
        logic [4:0]  r1s [7] = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0};
        logic [4:0]  r2s [7] = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [2:0]  f3s [7] = '{3'd0, 3'd2, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        logic [6:0]  f7s [7] = '{7'd0, 7'd0, 7'h20, 7'd0, 7'd0, 7'd0, 7'd0};
        logic [31:0] imms[7] = '{-32'sd8, 32'd8, 32'd0, -32'sd4, 32'd2048, 32'd4094, -32'sd2048};
        logic [31:0] exps[7] = '{32'hFE208CE3, 32'h0020A423, 32'h402081B3, 32'hFFC12283,
                                32'h001000EF, 32'h7E000FE3, 32'h80000013};
        bit acc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(ops[i], rds[i], r1s[i], r2s[i], f3s[i], f7s[i], imms[i], acc);
            total++;
            if (acc !== 1'b1) begin bad++; $display("FAIL fmt_accept_%0d got=%b expected=1", i, acc); end
            exp_q.push_back({exps[i], 32'(i * 4)});
        end
        wait_drain(ok);
        @(negedge clk);
        total += 2;
        if (!ok) begin bad++; $display("FAIL fmt_drain got=%0d left expected=0", exp_q.size()); end
        if (out_count !== 16'd7) begin bad++; $display("FAIL fmt_count got=%0d expected=7", out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        logic [6:0]  ops [8] = '{7'h6F, 7'h03, 7'h7F, 7'h63, 7'h63, 7'h6F, 7'h23, 7'h7F};
        logic [31:0] imms[8] = '{32'd3, 32'd2048, 32'd0, 32'd4097, -32'sd4098, 32'd1048576,
                                -32'sd2049, 32'd3};
        logic [1:0]  codes[8] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1};
        bit acc;
        bit ok;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(ops[i], 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, imms[i], acc);
            @(negedge clk);
            total += 3;
            if (acc !== 1'b1) begin bad++; $display("FAIL err_accept_%0d got=%b expected=1", i, acc); end
            if (err_valid !== 1'b1) begin bad++; $display("FAIL err_pulse_%0d got=%b expected=1", i, err_valid); end
            if (err_code !== codes[i]) begin bad++; $display("FAIL err_code_%0d got=%0d expected=%0d", i, err_code, codes[i]); end
            @(negedge clk);
            total++;
            if (err_valid !== 1'b0) begin bad++; $display("FAIL err_one_cycle_%0d got=%b expected=0", i, err_valid); end
            @(posedge clk);
            #1;
            if (i == 0) begin
                send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, acc);
                exp_q.push_back({32'h00500093, 32'h0});
            end
        end
        send(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, acc);
        exp_q.push_back({32'h0020A423, 32'h4});
        wait_drain(ok);
        @(negedge clk);
        total += 2;
        if (!ok) begin bad++; $display("FAIL err_drain got=%0d left expected=0", exp_q.size()); end
        if (out_count !== 16'd2) begin bad++; $display("FAIL err_count got=%0d expected=2", out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit found;
        bit ok;
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_op     = i_type_alu_op;
            in_rd     = 5'(i + 1);
            in_rs1    = 5'd0;
            in_rs2    = 5'd0;
            in_funct3 = 3'd0;
            in_funct7 = 7'd0;
            in_imm    = 32'(i + 1);
            in_valid  = 1'b1;
            @(negedge clk);
            total++;
            if (in_ready !== (i < 2)) begin bad++; $display("FAIL b2b_ready_%0d got=%b expected=%b", i, in_ready, (i < 2)); end
            if (in_ready) exp_q.push_back({12'(i + 1), 5'd0, 3'd0, 5'(i + 1), 7'h13, 32'(i * 4)});
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(negedge clk);
            total += 2;
            if (out_instr !== 32'h00100093) begin bad++; $display("FAIL b2b_hold_instr got=%h expected=00100093", out_instr); end
            if (out_addr !== 32'h0) begin bad++; $display("FAIL b2b_hold_addr got=%h expected=0", out_addr); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (in_ready) begin
                found = 1'b1;
                exp_q.push_back({32'h00300193, 32'h8});
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (!found) begin bad++; $display("FAIL b2b_third_accept got=0 expected=1"); end
        wait_drain(ok);
        @(negedge clk);
        total += 2;
        if (!ok) begin bad++; $display("FAIL b2b_drain got=%0d left expected=0", exp_q.size()); end
        if (out_count !== 16'd3) begin bad++; $display("FAIL b2b_count got=%0d expected=3", out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_restart();
        bit acc;
        bit ok;
        out_ready = 1'b0;
        send(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, acc);
        exp_q.push_back({32'h00700393, 32'hC});
        send(7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, acc);
        exp_q.push_back({32'h00700393, 32'h10});
        in_valid = 1'b1;
        restart  = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rs_ready got=%b expected=0", in_ready); end
        @(posedge clk);
        #1;
        restart = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_out_valid got=%b expected=0", out_valid); end
        if (out_count !== 16'd3) begin bad++; $display("FAIL rs_count_kept got=%0d expected=3", out_count); end
        @(posedge clk);
        #1;
        restart  = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rs_empty_ready got=%b expected=0", in_ready); end
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rs_empty_no_push got=%b expected=0", out_valid); end
        @(posedge clk);
        #1;
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, acc);
        exp_q.push_back({32'h00200113, 32'h0});
        out_ready = 1'b1;
        wait_drain(ok);
        @(negedge clk);
        total += 2;
        if (!ok) begin bad++; $display("FAIL rs_drain got=%0d left expected=0", exp_q.size()); end
        if (out_count !== 16'd4) begin bad++; $display("FAIL rs_count got=%0d expected=4", out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit acc;
        out_ready = 1'b0;
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, acc);
        exp_q.push_back({32'h00100093, 32'h4});
        send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, acc);
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rm_ready_low got=%b expected=0", in_ready); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_out_valid got=%b expected=0", out_valid); end
        if (err_valid !== 1'b0) begin bad++; $display("FAIL rm_err_valid got=%b expected=0", err_valid); end
        if (out_count !== 16'd0) begin bad++; $display("FAIL rm_count got=%0d expected=0", out_count); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b expected=1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        restart   = 1'b0;
        in_valid  = 1'b0;
        in_op     = i_type_alu_op;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_formats();
        test_errors();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue got=%0d left expected=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
